// File: rtl/rename_dispatch_queue_if.sv
// Handshake and payload bundle between Rename, the rename/dispatch queue and Dispatch.
// The laneActive_i lane mask exists only when RDQ_LANE_GATE_EN is defined.
// slave: the queue's view. master: the view of the driver that feeds and drains it.
`timescale 1ns/1ps
interface rename_dispatch_queue_if #(
  parameter int WIDTH = 4,
  parameter int PKT_W = 128,
  parameter int CNT_W = 3
);
  logic                   flush_i;
`ifdef RDQ_LANE_GATE_EN
  logic [WIDTH-1:0]       laneActive_i;
`endif
  logic                   bundleValid_i;
  logic [WIDTH-1:0]       laneValid_i;
  logic [WIDTH*PKT_W-1:0] pkt_i;
  logic                   bundleReady_o;
  logic                   bundleValid_o;
  logic [WIDTH-1:0]       laneValid_o;
  logic [WIDTH*PKT_W-1:0] pkt_o;
  logic                   bundleReady_i;
  logic [CNT_W-1:0]       count_o;

  modport slave (
    input  flush_i,
`ifdef RDQ_LANE_GATE_EN
    input  laneActive_i,
`endif
    input  bundleValid_i,
    input  laneValid_i,
    input  pkt_i,
    output bundleReady_o,
    output bundleValid_o,
    output laneValid_o,
    output pkt_o,
    input  bundleReady_i,
    output count_o
  );

  modport master (
    output flush_i,
`ifdef RDQ_LANE_GATE_EN
    output laneActive_i,
`endif
    output bundleValid_i,
    output laneValid_i,
    output pkt_i,
    input  bundleReady_o,
    input  bundleValid_o,
    input  laneValid_o,
    input  pkt_o,
    output bundleReady_i,
    input  count_o
  );
endinterface

// File: rtl/rename_dispatch_queue.sv
// rename_dispatch_queue: DEPTH-entry circular buffer of dispatch bundles between
// Rename and Dispatch. Each side uses a valid/ready handshake, and every lane has
// its own valid bit. A flush empties the queue in one cycle.
// Optional lane gating is enabled by defining RDQ_LANE_GATE_EN. With it, the
// laneActive_i mask qualifies the lane valids and zeroes inactive output lanes.
// It also suppresses writes to inactive lane storage.
`timescale 1ns/1ps
module rename_dispatch_queue #(
  parameter int WIDTH = 4,
  parameter int PKT_W = 128,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                    clk,
  input logic                    reset,
  rename_dispatch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]       r_lv [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;

  logic [WIDTH-1:0]       w_lane_act;
  logic [WIDTH-1:0]       w_eff_lv;
  logic                   w_ready;
  logic                   w_valid;
  logic                   w_nonempty;
  logic                   w_push;
  logic                   w_pop;
  logic [WIDTH*PKT_W-1:0] w_rd_pkt;

`ifdef RDQ_LANE_GATE_EN
  assign w_lane_act = bus.laneActive_i;
`else
  assign w_lane_act = '1;
`endif

  assign w_eff_lv   = bus.laneValid_i & w_lane_act;
  assign w_nonempty = (r_count != '0);
  // Both handshake outputs come only from registered occupancy and the flush input.
  assign w_ready    = (r_count != CNT_W'(DEPTH)) & ~bus.flush_i;
  assign w_valid    = w_nonempty & ~bus.flush_i;
  // A bundle whose lanes are all invalid is accepted but is not stored.
  assign w_push     = bus.bundleValid_i & w_ready & (|w_eff_lv);
  assign w_pop      = w_valid & bus.bundleReady_i;

  assign bus.bundleReady_o = w_ready;
  assign bus.bundleValid_o = w_valid;
  assign bus.laneValid_o   = w_valid ? (r_lv[r_rd_ptr] & w_lane_act) : '0;
  assign bus.pkt_o         = w_rd_pkt;
  assign bus.count_o       = r_count;

  // Pointer and occupancy update. Reset and flush both squash any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Lane-valid storage for the tail entry. Entry contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_lv[r_wr_ptr] <= w_eff_lv;
  end

  // Each lane has its own payload storage, so an inactive lane's slice is never written.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    logic [PKT_W-1:0] r_mem [DEPTH];

    // Write this lane's slice only when the lane is active at the push.
    always_ff @(posedge clk) begin
      if (w_push && !reset && w_lane_act[g]) r_mem[r_wr_ptr] <= bus.pkt_i[g*PKT_W +: PKT_W];
    end

    // Holding the output at zero while the queue is empty keeps never-written entries off pkt_o.
    assign w_rd_pkt[g*PKT_W +: PKT_W] = (w_nonempty && w_lane_act[g]) ? r_mem[r_rd_ptr] : '0;
  end
endmodule

// File: tb/tb_rename_dispatch_queue.sv
// Bench for rename_dispatch_queue. A queue-of-bundles reference model is checked
// against the DUT every cycle. Directed steps also check hand-computed literal values.
// The lane-gating section is included when RDQ_LANE_GATE_EN is defined.
`timescale 1ns/1ps
module tb_rename_dispatch_queue;
  localparam int WIDTH = 4;
  localparam int PKT_W = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int BW    = WIDTH * PKT_W;

  typedef struct {
    logic [WIDTH-1:0] lv;
    logic [BW-1:0]    pkt;
  } bundle_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rename_dispatch_queue_if #(.WIDTH(WIDTH), .PKT_W(PKT_W), .CNT_W(CNT_W)) bus ();

  rename_dispatch_queue #(.WIDTH(WIDTH), .PKT_W(PKT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  bundle_t          q[$];
  bundle_t          nb;
  logic [WIDTH-1:0] act;
  logic             m_valid, m_ready, m_push, m_pop;

`ifdef RDQ_LANE_GATE_EN
  assign act = bus.laneActive_i;
`else
  assign act = '1;
`endif

  function automatic logic [BW-1:0] mk(input int tag);
    logic [BW-1:0] p;
    for (int l = 0; l < WIDTH; l++) p[l*PKT_W +: PKT_W] = 32'hA000_0000 + 32'(tag * 16 + l);
    return p;
  endfunction

  function automatic logic [BW-1:0] lane_mask(input logic [WIDTH-1:0] a);
    logic [BW-1:0] m;
    m = '0;
    for (int l = 0; l < WIDTH; l++) if (a[l]) m[l*PKT_W +: PKT_W] = '1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: compare outputs at the falling edge, then advance the model with the inputs held into the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
      end else begin
        m_valid = (q.size() != 0) && !bus.flush_i;
        m_ready = (q.size() != DEPTH) && !bus.flush_i;
        chk("m_ready", BW'(bus.bundleReady_o), BW'(m_ready));
        chk("m_valid", BW'(bus.bundleValid_o), BW'(m_valid));
        chk("m_count", BW'(bus.count_o), BW'(q.size()));
        if (m_valid) begin
          chk("m_lanevalid", BW'(bus.laneValid_o), BW'(q[0].lv & act));
          chk("m_pkt", bus.pkt_o, q[0].pkt & lane_mask(act));
        end else begin
          chk("m_lanevalid_idle", BW'(bus.laneValid_o), '0);
        end
        if (bus.flush_i) begin
          q.delete();
        end else begin
          m_pop  = m_valid && bus.bundleReady_i;
          m_push = bus.bundleValid_i && m_ready && (|(bus.laneValid_i & act));
          if (m_pop) void'(q.pop_front());
          if (m_push) begin
            nb.lv  = bus.laneValid_i & act;
            nb.pkt = bus.pkt_i;
            q.push_back(nb);
          end
        end
      end
    end
  end

  task automatic step(input logic bv, input logic [WIDTH-1:0] lv, input logic [BW-1:0] pk,
                      input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    bus.bundleValid_i = bv;
    bus.laneValid_i   = lv;
    bus.pkt_i         = pk;
    bus.bundleReady_i = rdy;
    bus.flush_i       = fl;
    #2;
  endtask

  logic [BW-1:0] exp_pkt;

  initial begin
    reset             = 1'b1;
    bus.flush_i       = 1'b0;
    bus.bundleValid_i = 1'b0;
    bus.laneValid_i   = '0;
    bus.pkt_i         = '0;
    bus.bundleReady_i = 1'b0;
`ifdef RDQ_LANE_GATE_EN
    bus.laneActive_i  = '1;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_count", BW'(bus.count_o), '0);
    chk("rst_ready", BW'(bus.bundleReady_o), BW'(1'b1));
    chk("rst_valid", BW'(bus.bundleValid_o), '0);
    chk("rst_lanevalid", BW'(bus.laneValid_o), '0);

    // Single bundle: no bypass, visible the next cycle, then popped.
    step(1'b1, 4'b1011, mk(1), 1'b1, 1'b0);
    chk("nobypass_valid", BW'(bus.bundleValid_o), '0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("a_valid", BW'(bus.bundleValid_o), BW'(1'b1));
    chk("a_lanevalid", BW'(bus.laneValid_o), BW'(4'b1011));
    chk("a_pkt", bus.pkt_o, mk(1));
    chk("a_count", BW'(bus.count_o), BW'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("a_popped_count", BW'(bus.count_o), '0);
    chk("a_popped_valid", BW'(bus.bundleValid_o), '0);

    // Backpressure: only DEPTH bundles accepted, then drained in order.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b1111, mk(10 + i), 1'b0, 1'b0);
      chk("bp_count", BW'(bus.count_o), BW'((i < 4) ? i : 4));
      chk("bp_ready", BW'(bus.bundleReady_o), BW'(i < 4));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_pkt", bus.pkt_o, mk(10 + i));
      chk("drain_count", BW'(bus.count_o), BW'(4 - i));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_empty", BW'(bus.count_o), '0);

    // Full queue, push and pop together: the pop wins, the push is refused.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, mk(20 + i), 1'b0, 1'b0);
    step(1'b1, 4'b1111, mk(30), 1'b1, 1'b0);
    chk("full_ready", BW'(bus.bundleReady_o), '0);
    chk("full_count", BW'(bus.count_o), BW'(4));
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_after_count", BW'(bus.count_o), BW'(3));
    chk("full_after_ready", BW'(bus.bundleReady_o), BW'(1'b1));
    chk("full_after_head", bus.pkt_o, mk(21));
    repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("full_drained", BW'(bus.count_o), '0);

    // Steady state at count 2 with a push and a pop every cycle; the pointers wrap.
    step(1'b1, 4'b0011, mk(40), 1'b0, 1'b0);
    step(1'b1, 4'b0110, mk(41), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b1111, mk(50 + i), 1'b1, 1'b0);
      chk("steady_count", BW'(bus.count_o), BW'(2));
    end
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("steady_drained", BW'(bus.count_o), '0);

    // All-invalid bundle is dropped without changing occupancy.
    step(1'b1, 4'b1111, mk(61), 1'b0, 1'b0);
    step(1'b1, 4'b0000, mk(62), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("drop_count", BW'(bus.count_o), BW'(1));

    // Flush at count 3 while also pushing.
    step(1'b1, 4'b1111, mk(63), 1'b0, 1'b0);
    step(1'b1, 4'b1111, mk(64), 1'b0, 1'b0);
    step(1'b1, 4'b1111, mk(65), 1'b0, 1'b1);
    chk("flush_cycle_count", BW'(bus.count_o), BW'(3));
    chk("flush_cycle_valid", BW'(bus.bundleValid_o), '0);
    chk("flush_cycle_ready", BW'(bus.bundleReady_o), '0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_after_count", BW'(bus.count_o), '0);
    chk("flush_after_valid", BW'(bus.bundleValid_o), '0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef RDQ_LANE_GATE_EN
    // Lane gating: inactive lanes are masked out and zeroed on the output.
    bus.laneActive_i = 4'b0011;
    step(1'b1, 4'b1111, mk(70), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    exp_pkt = mk(70);
    exp_pkt[BW-1:2*PKT_W] = '0;
    chk("gate_lanevalid", BW'(bus.laneValid_o), BW'(4'b0011));
    chk("gate_pkt", bus.pkt_o, exp_pkt);
    chk("gate_count", BW'(bus.count_o), BW'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 4'b1100, mk(71), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("gate_drop_count", BW'(bus.count_o), '0);
    chk("gate_drop_valid", BW'(bus.bundleValid_o), '0);
`endif

    step(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rename_dispatch_queue.md
# rename_dispatch_queue

Parametrised elastic bundle queue between the Rename and Dispatch stages. It replaces the single-entry stall/flush pipeline register with a DEPTH-entry circular buffer of dispatch bundles, using a valid/ready handshake on both sides and per-lane valid bits. The rename stage can keep producing while dispatch stalls, up to DEPTH bundles. Flush empties the queue in one cycle.

## Interface
Parameters:
- `WIDTH`, default 4: lanes per bundle (dispatch width), 1..8.
- `PKT_W`, default 128: bits per lane packet (disPkt size).
- `DEPTH`, default 4: bundle entries. Must be a power of two and ≥ 2.
- `CNT_W`, default $clog2(DEPTH+1): occupancy counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush_i` in 1: synchronous squash of all entries.
- `laneActive_i` in WIDTH: lane power/enable mask. Present only with `RDQ_LANE_GATE_EN`.
- `bundleValid_i` in 1: rename offers a bundle this cycle.
- `laneValid_i` in WIDTH: per-lane instruction valid for the offered bundle.
- `pkt_i` in WIDTH*PKT_W: lane i occupies bits [i*PKT_W +: PKT_W].
- `bundleReady_o` out 1: queue can accept a bundle this cycle.
- `bundleValid_o` out 1: head bundle is valid.
- `laneValid_o` out WIDTH: per-lane valid of the head bundle.
- `pkt_o` out WIDTH*PKT_W: head bundle payload.
- `bundleReady_i` in 1: dispatch consumes the head this cycle.
- `count_o` out CNT_W: current occupancy, 0..DEPTH.

## Operation
- State: entry array `mem[DEPTH]`, each entry holding {laneValid, pkt}; head pointer `rdPtr`, tail pointer `wrPtr` (both log2(DEPTH) bits, wrap naturally); occupancy `count`.
- `bundleReady_o = (count != DEPTH) & ~flush_i`. It depends on registered state only, with no combinational path from `bundleReady_i`.
- push = `bundleValid_i & bundleReady_o & (|effLaneValid)`.
  - `effLaneValid = laneValid_i` (masked by `laneActive_i` when gating is enabled).
  - An offered bundle with all lanes invalid is accepted but dropped: it is not written and the counters are unchanged.
- pop = `bundleValid_o & bundleReady_i`.
- `bundleValid_o = (count != 0) & ~flush_i`.
- `laneValid_o = mem[rdPtr].laneValid` when `bundleValid_o`, else 0.
- `pkt_o = mem[rdPtr].pkt`. Its value is don't-care while `bundleValid_o = 0`, but it must not be X after the first write.
- push: `mem[wrPtr] <= {effLaneValid, pkt_i}`, then `wrPtr++`.
- pop: `rdPtr++`.
- count: `count <= count + push - pop`.
- Simultaneous push and pop: both take effect and count is unchanged.
  - At count == DEPTH, push is blocked (`bundleReady_o = 0`) even if a pop occurs in the same cycle.
- reset or flush_i: `rdPtr`, `wrPtr` and `count` go to 0 at the next edge. Any push or pop in that cycle is ignored. Entry contents are not cleared.
- reset has priority over flush. Both produce the same end state.

## Timing
- Reset values: `bundleReady_o = 1` (0 while reset is asserted is also acceptable; the bench samples after deassertion), `bundleValid_o = 0`, `laneValid_o = 0`, `count_o = 0`.
- Latency: a bundle pushed at edge N is visible on the outputs after edge N (bundleValid_o high in cycle N+1). There is no same-cycle bypass.
- Throughput: 1 bundle/cycle sustained when dispatch is always ready.
- Backpressure: with `bundleReady_i = 0`, exactly DEPTH bundles are accepted, then `bundleReady_o` falls in the cycle after the DEPTH-th push.
- After a flush, the outputs are quiet in the flush cycle (`bundleValid_o = 0`, `bundleReady_o = 0`). Normal operation resumes the next cycle with an empty queue.

## Configuration
- `RDQ_LANE_GATE_EN` defined:
  - The `laneActive_i` port exists. Input lane valids are ANDed with it at push.
  - `laneValid_o` is ANDed with the current `laneActive_i`.
  - The `pkt_o` slice of any inactive lane is driven to 0 (isolation emulation).
  - Writes to inactive lane slices of `mem` are suppressed, to model clock gating.
- Not defined: no `laneActive_i` port. All lanes are treated as active and there is no output zeroing.

## Test plan
- Reset, then push bundle A with `laneValid_i = 4'b1011` and `bundleReady_i = 1` every cycle → in the next cycle, `bundleValid_o = 1`, `laneValid_o = 4'b1011`, `pkt_o = A`, `count_o = 1`, then 0 after the pop.
- Hold `bundleReady_i = 0` and push continuously → exactly 4 bundles (DEPTH = 4) accepted, `count_o = 4`, `bundleReady_o = 0`. Release → the bundles pop out in order, one per cycle.
- Full queue with push and pop asserted in the same cycle → the pop succeeds, the push is refused, `count_o` goes to 3. Next cycle `bundleReady_o = 1`.
- Queue at count 2 with push and pop in the same cycle → `count_o` stays 2. Pointers wrap correctly across 8+ transfers and data order is preserved.
- Assert `flush_i` with count 3 while also pushing → next cycle `count_o = 0`, `bundleValid_o = 0`. The pushed bundle is never emitted.
- With `RDQ_LANE_GATE_EN` and `laneActive_i = 4'b0011`, push `laneValid_i = 4'b1111` → `laneValid_o = 4'b0011` and the `pkt_o` lanes 2–3 are 0. Push `laneValid_i = 4'b1100` → the bundle is dropped and `count_o` is unchanged.
